// File: rtl/cfs_md_chk_pkg.sv
// Shared types for the MD protocol checker: rule indices, channel states,
// and width helpers for the packed offset/size/channel fields.
package cfs_md_chk_pkg;

  localparam int NUM_RULES = 6;

  typedef enum logic [2:0] {
    VALID_DROP  = 3'd0,
    PAYLOAD_CHG = 3'd1,
    SIZE_OFS    = 3'd2,
    SIZE0       = 3'd3,
    ERR_OUTSIDE = 3'd4,
    TIMEOUT     = 3'd5
  } rule_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ch_state_e;

  function automatic int ofs_w(input int dw);
    return ($clog2(dw / 8) > 1) ? $clog2(dw / 8) : 1;
  endfunction

  function automatic int size_w(input int dw);
    return $clog2(dw / 8) + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfs_md_chk_channel.sv
// One MD channel: transfer FSM, payload capture, stall timer, transfer count.
// Ports: MD link + chk_en/timeout_limit/clr in; per-rule viol pulses, xfer_cnt out.
module cfs_md_chk_channel
  import cfs_md_chk_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_W   = 8,
  parameter int CNT_W       = 16,
  parameter int ALLOW_SIZE0 = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          valid,
  input  logic                          ready,
  input  logic                          err,
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic [ofs_w(DATA_WIDTH)-1:0]  offset,
  input  logic [size_w(DATA_WIDTH)-1:0] size,
  input  logic                          chk_en,
  input  logic [TIMEOUT_W-1:0]          timeout_limit,
  input  logic                          clr,
  output logic [NUM_RULES-1:0]          viol,
  output logic [CNT_W-1:0]              xfer_cnt
);

  localparam int OW = ofs_w(DATA_WIDTH);
  localparam int SW = size_w(DATA_WIDTH);
  localparam logic [SW:0] BYTES = (SW+1)'(DATA_WIDTH / 8);

  ch_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]  cap_data_q;
  logic [OW-1:0]          cap_ofs_q;
  logic [SW-1:0]          cap_size_q;
  logic [TIMEOUT_W-1:0]   stall_q, stall_d;
  logic                   to_done_q, to_done_d;
  logic                   capture;
  logic                   xfer;
  logic                   stall;
  logic [SW:0]            span;
  logic [CNT_W-1:0]       cnt_base;

  assign xfer  = valid & ready;
  assign stall = valid & ~ready;
  // One extra bit so size+offset can never wrap.
  assign span  = {1'b0, size} + {{(SW+1-OW){1'b0}}, offset};

  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    to_done_d = to_done_q;
    capture   = 1'b0;
    viol      = '0;
    if (!chk_en) begin
      state_d   = IDLE;
      stall_d   = '0;
      to_done_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (stall) begin
            state_d = WAIT;
            stall_d = TIMEOUT_W'(1);
            capture = 1'b1;
          end
        end
        WAIT: begin
          if (!valid) begin
            state_d   = IDLE;
            stall_d   = '0;
            to_done_d = 1'b0;
            viol[VALID_DROP] = 1'b1;
          end else if (ready) begin
            state_d   = IDLE;
            stall_d   = '0;
            to_done_d = 1'b0;
          end else if (stall_q != '1) begin
            stall_d = stall_q + 1'b1;
          end
        end
      endcase
      if (state_q == WAIT && valid &&
          (data != cap_data_q || offset != cap_ofs_q ||
           size != cap_size_q))
        viol[PAYLOAD_CHG] = 1'b1;
      viol[SIZE_OFS]    = valid && (span > BYTES);
      viol[SIZE0]       = valid && (size == '0) && (ALLOW_SIZE0 == 0);
      viol[ERR_OUTSIDE] = err && !xfer;
      // Fires on the edge the counter reaches the limit; once per stall.
      if (state_d == WAIT && timeout_limit != '0 &&
          stall_d == timeout_limit && !to_done_q) begin
        viol[TIMEOUT] = 1'b1;
        to_done_d     = 1'b1;
      end
    end
  end

  assign cnt_base = clr ? '0 : xfer_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      stall_q    <= '0;
      to_done_q  <= 1'b0;
      cap_data_q <= '0;
      cap_ofs_q  <= '0;
      cap_size_q <= '0;
      xfer_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      to_done_q <= to_done_d;
      if (capture) begin
        cap_data_q <= data;
        cap_ofs_q  <= offset;
        cap_size_q <= size;
      end
      if (xfer && cnt_base != '1)
        xfer_cnt <= cnt_base + 1'b1;
      else
        xfer_cnt <= cnt_base;
    end
  end

endmodule

// File: rtl/cfs_md_protocol_checker.sv
// Passive multi-channel MD protocol checker: sticky rule flags, first-error
// capture, irq and per-channel transfer counts. Channel 0 in packed LSBs.
module cfs_md_protocol_checker
  import cfs_md_chk_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 2,
  parameter int TIMEOUT_W   = 8,
  parameter int CNT_W       = 16,
  parameter int ALLOW_SIZE0 = 0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_CH-1:0]                    md_valid,
  input  logic [NUM_CH-1:0]                    md_ready,
  input  logic [NUM_CH-1:0]                    md_err,
  input  logic [NUM_CH*DATA_WIDTH-1:0]         md_data,
  input  logic [NUM_CH*ofs_w(DATA_WIDTH)-1:0]  md_offset,
  input  logic [NUM_CH*size_w(DATA_WIDTH)-1:0] md_size,
  input  logic [NUM_CH-1:0]                    chk_en,
  input  logic [TIMEOUT_W-1:0]                 timeout_limit,
  input  logic                                 clr,
  output logic [NUM_CH*NUM_RULES-1:0]          viol_sticky,
  output logic                                 first_vld,
  output logic [idx_w(NUM_CH)-1:0]             first_ch,
  output logic [2:0]                           first_rule,
  output logic                                 irq,
  output logic [NUM_CH*CNT_W-1:0]              xfer_cnt
);

  localparam int OW  = ofs_w(DATA_WIDTH);
  localparam int SW  = size_w(DATA_WIDTH);
  localparam int CHW = idx_w(NUM_CH);

  if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a power of 2 and >= 8");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
    $error("NUM_CH must be in 1..16");
  end

  logic [NUM_CH*NUM_RULES-1:0] viol_all;
  logic                        hit;
  logic [CHW-1:0]              hit_ch;
  logic [2:0]                  hit_rule;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cfs_md_chk_channel #(
      .DATA_WIDTH  (DATA_WIDTH),
      .TIMEOUT_W   (TIMEOUT_W),
      .CNT_W       (CNT_W),
      .ALLOW_SIZE0 (ALLOW_SIZE0)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .valid         (md_valid[g]),
      .ready         (md_ready[g]),
      .err           (md_err[g]),
      .data          (md_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .offset        (md_offset[g*OW +: OW]),
      .size          (md_size[g*SW +: SW]),
      .chk_en        (chk_en[g]),
      .timeout_limit (timeout_limit),
      .clr           (clr),
      .viol          (viol_all[g*NUM_RULES +: NUM_RULES]),
      .xfer_cnt      (xfer_cnt[g*CNT_W +: CNT_W])
    );
  end

  // Scan high to low so the lowest channel, then lowest rule, wins.
  always_comb begin
    hit      = 1'b0;
    hit_ch   = '0;
    hit_rule = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      for (int r = NUM_RULES - 1; r >= 0; r--) begin
        if (viol_all[c*NUM_RULES + r]) begin
          hit      = 1'b1;
          hit_ch   = CHW'(c);
          hit_rule = 3'(r);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      viol_sticky <= '0;
      first_vld   <= 1'b0;
      first_ch    <= '0;
      first_rule  <= '0;
      irq         <= 1'b0;
    end else begin
      viol_sticky <= (clr ? '0 : viol_sticky) | viol_all;
      irq         <= |viol_sticky;
      // clr wins first, so a same-edge violation becomes the new first.
      if ((clr || !first_vld) && hit) begin
        first_vld  <= 1'b1;
        first_ch   <= hit_ch;
        first_rule <= hit_rule;
      end else if (clr) begin
        first_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cfs_md_protocol_checker.sv
// Self-checking bench for cfs_md_protocol_checker: directed vector table,
// hand-written corner sequences and randomized traffic against a rule model.
module tb_cfs_md_protocol_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  md_valid, md_ready, md_err, chk_en;
  logic [63:0] md_data;
  logic [3:0]  md_offset;
  logic [5:0]  md_size;
  logic [7:0]  timeout_limit;
  logic        clr;
  logic [11:0] viol_sticky;
  logic        first_vld;
  logic [0:0]  first_ch;
  logic [2:0]  first_rule;
  logic        irq;
  logic [31:0] xfer_cnt;

  int checks = 0;
  int failures = 0;

  cfs_md_protocol_checker dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .md_valid      (md_valid),
    .md_ready      (md_ready),
    .md_err        (md_err),
    .md_data       (md_data),
    .md_offset     (md_offset),
    .md_size       (md_size),
    .chk_en        (chk_en),
    .timeout_limit (timeout_limit),
    .clr           (clr),
    .viol_sticky   (viol_sticky),
    .first_vld     (first_vld),
    .first_ch      (first_ch),
    .first_rule    (first_rule),
    .irq           (irq),
    .xfer_cnt      (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a pending stalled transfer per channel, its captured
  // payload and how many stalled edges it has seen so far.
  bit          m_busy[2];
  logic [31:0] m_cd[2];
  int          m_co[2], m_cs[2], m_len[2], m_cnt[2];
  bit          m_fired[2];
  bit   [11:0] m_st;
  bit          m_fv, m_irq;
  int          m_fch, m_frule;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_busy[c] = 0; m_cd[c] = '0; m_co[c] = 0; m_cs[c] = 0;
      m_len[c] = 0; m_cnt[c] = 0; m_fired[c] = 0;
    end
    m_st = '0; m_fv = 0; m_irq = 0; m_fch = 0; m_frule = 0;
  endtask

  task automatic model_edge();
    bit [11:0] v;
    bit vv, rr, ee, found;
    logic [31:0] d;
    int o, s;
    v = '0;
    for (int c = 0; c < 2; c++) begin
      vv = md_valid[c]; rr = md_ready[c]; ee = md_err[c];
      d = md_data[c*32 +: 32];
      o = int'(md_offset[c*2 +: 2]);
      s = int'(md_size[c*3 +: 3]);
      if (clr) m_cnt[c] = 0;
      if (vv && rr && m_cnt[c] < 65535) m_cnt[c]++;
      if (!chk_en[c]) begin
        m_busy[c] = 0; m_len[c] = 0; m_fired[c] = 0;
      end else begin
        if (m_busy[c] && !vv) v[c*6+0] = 1;
        if (m_busy[c] && vv &&
            (d != m_cd[c] || o != m_co[c] || s != m_cs[c])) v[c*6+1] = 1;
        if (vv && s + o > 4) v[c*6+2] = 1;
        if (vv && s == 0) v[c*6+3] = 1;
        if (ee && !(vv && rr)) v[c*6+4] = 1;
        if (vv && !rr) begin
          if (!m_busy[c]) begin
            m_busy[c] = 1; m_len[c] = 1; m_fired[c] = 0;
            m_cd[c] = d; m_co[c] = o; m_cs[c] = s;
          end else if (m_len[c] < 255) begin
            m_len[c]++;
          end
          if (timeout_limit != 0 && m_len[c] == int'(timeout_limit) &&
              !m_fired[c]) begin
            v[c*6+5] = 1; m_fired[c] = 1;
          end
        end else begin
          m_busy[c] = 0; m_len[c] = 0; m_fired[c] = 0;
        end
      end
    end
    m_irq = |m_st;
    if (clr) begin m_st = '0; m_fv = 0; end
    m_st |= v;
    found = 0;
    // Bit index ch*6+rule: lowest set bit is lowest channel, then rule.
    if (!m_fv)
      for (int i = 0; i < 12; i++)
        if (v[i] && !found) begin
          found = 1; m_fv = 1; m_fch = i / 6; m_frule = i % 6;
        end
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("sticky", 64'(viol_sticky), 64'(m_st));
    chk("first_vld", 64'(first_vld), 64'(m_fv));
    if (m_fv) begin
      chk("first_ch", 64'(first_ch), 64'(m_fch));
      chk("first_rule", 64'(first_rule), 64'(m_frule));
    end
    chk("irq", 64'(irq), 64'(m_irq));
    chk("cnt0", 64'(xfer_cnt[15:0]), 64'(m_cnt[0]));
    chk("cnt1", 64'(xfer_cnt[31:16]), 64'(m_cnt[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic drive(input logic [1:0] v, r, e, input logic [31:0] d0, d1,
                       input logic [1:0] o0, o1, input logic [2:0] s0, s1,
                       input logic c);
    md_valid = v; md_ready = r; md_err = e;
    md_data = {d1, d0}; md_offset = {o1, o0}; md_size = {s1, s0};
    clr = c;
  endtask

  typedef struct {
    logic [1:0]  v, r, e;
    logic [31:0] d0, d1;
    logic [1:0]  o0, o1;
    logic [2:0]  s0, s1;
    logic        c;
    logic [11:0] st;
    logic        irq, fv, fch;
    logic [2:0]  fr;
    int          c0, c1;
  } vec_t;

  vec_t tbl[12];

  logic [31:0] rd[2];
  logic [1:0]  ro[2];
  logic [2:0]  rs[2];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    //         v     r     e     d0            d1     o0 o1 s0 s1 clr  st     irq fv fch fr c0 c1
    tbl[0]  = '{2'b01,2'b00,2'b00,32'hA5A5_0000,32'h0, 0, 0, 4, 4, 0, 12'h000,0, 0, 0, 0, 0, 0};
    tbl[1]  = '{2'b01,2'b00,2'b00,32'hA5A5_0000,32'h0, 0, 0, 4, 4, 0, 12'h000,0, 0, 0, 0, 0, 0};
    tbl[2]  = '{2'b01,2'b00,2'b00,32'hA5A5_0000,32'h0, 0, 0, 4, 4, 0, 12'h000,0, 0, 0, 0, 0, 0};
    tbl[3]  = '{2'b01,2'b01,2'b00,32'hA5A5_0000,32'h0, 0, 0, 4, 4, 0, 12'h000,0, 0, 0, 0, 1, 0};
    tbl[4]  = '{2'b00,2'b00,2'b00,32'h0,        32'h0, 0, 0, 4, 4, 0, 12'h000,0, 0, 0, 0, 1, 0};
    tbl[5]  = '{2'b10,2'b00,2'b00,32'h0,        32'h11,0, 0, 4, 4, 0, 12'h000,0, 0, 0, 0, 1, 0};
    tbl[6]  = '{2'b10,2'b00,2'b00,32'h0,        32'h22,0, 0, 4, 4, 0, 12'h080,0, 1, 1, 1, 1, 0};
    tbl[7]  = '{2'b10,2'b10,2'b00,32'h0,        32'h22,0, 0, 4, 4, 0, 12'h080,1, 1, 1, 1, 1, 1};
    tbl[8]  = '{2'b00,2'b00,2'b00,32'h0,        32'h0, 0, 0, 4, 4, 1, 12'h000,1, 0, 0, 0, 0, 0};
    tbl[9]  = '{2'b10,2'b00,2'b00,32'h0,        32'h33,0, 0, 4, 4, 0, 12'h000,0, 0, 0, 0, 0, 0};
    tbl[10] = '{2'b01,2'b01,2'b00,32'hA5A5_0000,32'h33,3, 0, 2, 4, 0, 12'h044,0, 1, 0, 2, 1, 0};
    tbl[11] = '{2'b00,2'b00,2'b00,32'h0,        32'h0, 0, 0, 4, 4, 0, 12'h044,1, 1, 0, 2, 1, 0};

    reset_n = 1'b0;
    chk_en = 2'b11;
    timeout_limit = 8'd0;
    drive(0, 0, 0, 0, 0, 0, 0, 4, 4, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model();
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].e, tbl[i].d0, tbl[i].d1,
            tbl[i].o0, tbl[i].o1, tbl[i].s0, tbl[i].s1, tbl[i].c);
      step();
      chk($sformatf("tbl%0d_sticky", i), 64'(viol_sticky), 64'(tbl[i].st));
      chk($sformatf("tbl%0d_irq", i), 64'(irq), 64'(tbl[i].irq));
      chk($sformatf("tbl%0d_fvld", i), 64'(first_vld), 64'(tbl[i].fv));
      if (tbl[i].fv) begin
        chk($sformatf("tbl%0d_fch", i), 64'(first_ch), 64'(tbl[i].fch));
        chk($sformatf("tbl%0d_frule", i), 64'(first_rule), 64'(tbl[i].fr));
      end
      chk($sformatf("tbl%0d_cnt0", i), 64'(xfer_cnt[15:0]), 64'(tbl[i].c0));
      chk($sformatf("tbl%0d_cnt1", i), 64'(xfer_cnt[31:16]), 64'(tbl[i].c1));
    end

    // Timeout: limit 4, ch0 stalled 10 edges.
    drive(0, 0, 0, 0, 0, 0, 0, 4, 4, 1);
    step();
    timeout_limit = 8'd4;
    drive(2'b01, 0, 0, 32'h5, 0, 0, 0, 4, 4, 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("to_bit_e%0d", k), 64'(viol_sticky[5]), 64'(k >= 4));
      if (k == 4) begin
        chk("to_first_vld", 64'(first_vld), 64'd1);
        chk("to_first_rule", 64'(first_rule), 64'd5);
        chk("to_first_ch", 64'(first_ch), 64'd0);
      end
    end
    drive(2'b01, 2'b01, 0, 32'h5, 0, 0, 0, 4, 4, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 4, 4, 0);
    step();
    chk("to_irq", 64'(irq), 64'd1);

    // clr on the same edge as ch1 err outside a handshake.
    drive(0, 0, 2'b10, 0, 0, 0, 0, 4, 4, 1);
    step();
    chk("clr_err_sticky", 64'(viol_sticky), 64'h400);
    chk("clr_err_fvld", 64'(first_vld), 64'd1);
    chk("clr_err_fch", 64'(first_ch), 64'd1);
    chk("clr_err_frule", 64'(first_rule), 64'd4);

    // Async reset mid-WAIT, then a ready-only pulse.
    drive(2'b01, 0, 0, 32'h77, 0, 0, 0, 4, 4, 0);
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_sticky", 64'(viol_sticky), 64'd0);
    chk("rst_fvld", 64'(first_vld), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_cnt", 64'(xfer_cnt), 64'd0);
    model_reset();
    drive(0, 2'b01, 0, 0, 0, 0, 0, 4, 4, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("rst_no_drop", 64'(viol_sticky), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 4, 4, 0);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 2; c++) begin
      rd[c] = $urandom; ro[c] = 2'd0; rs[c] = 3'd4;
    end
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] v, r, e;
      for (int c = 0; c < 2; c++) begin
        if (m_busy[c]) begin
          v[c] = ($urandom % 20) != 0;
          if ($urandom % 25 == 0) rd[c] = $urandom;
        end else begin
          v[c] = ($urandom % 3) != 0;
          if ($urandom % 4 == 0) begin
            rd[c] = $urandom;
            ro[c] = ($urandom % 5 == 0) ? 2'($urandom) : 2'd0;
            rs[c] = ($urandom % 6 == 0) ? 3'($urandom) : 3'd4;
          end
        end
        r[c] = ($urandom % 4) == 0;
        e[c] = ($urandom % 40) == 0;
      end
      if ($urandom % 60 == 0) chk_en = chk_en ^ 2'($urandom);
      if ($urandom % 30 == 0) timeout_limit = 8'($urandom % 8);
      drive(v, r, e, rd[0], rd[1], ro[0], ro[1], rs[0], rs[1],
            ($urandom % 40) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfs_md_protocol_checker.md
Name: cfs_md_protocol_checker

Overview:
Synthesizable, multi-channel MD protocol checker that can stay in silicon and in emulation. It sits passively beside NUM_CH MD links (valid/ready/data/offset/size/err) and tracks each transfer with a per-channel FSM. It flags protocol violations as sticky status bits, captures the first violation, raises an interrupt, counts completed transfers, and adds a programmable ready-timeout check.

Parameters:
DATA_WIDTH, 32, MD data width in bits; power of 2, >= 8 (elaboration $error otherwise)
NUM_CH, 2, number of monitored MD channels, 1..16
TIMEOUT_W, 8, width of the ready-timeout counter and limit
CNT_W, 16, width of the per-channel completed-transfer counter
ALLOW_SIZE0, 0, 1 = size==0 is legal (rule SIZE0 disabled)
Derived: OFFSET_WIDTH = max(1, clog2(DATA_WIDTH/8)); SIZE_WIDTH = clog2(DATA_WIDTH/8)+1; NUM_RULES = 6

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
md_valid  in  NUM_CH  per-channel valid
md_ready  in  NUM_CH  per-channel ready
md_err  in  NUM_CH  per-channel err
md_data  in  NUM_CH*DATA_WIDTH  packed data, channel 0 in LSBs
md_offset  in  NUM_CH*OFFSET_WIDTH  packed offset
md_size  in  NUM_CH*SIZE_WIDTH  packed size
chk_en  in  NUM_CH  per-channel check enable
timeout_limit  in  TIMEOUT_W  stall limit in cycles; 0 = timeout check off
clr  in  1  one-cycle pulse; clears sticky flags, first-error capture, counters
viol_sticky  out  NUM_CH*NUM_RULES  sticky violation flags, [ch*NUM_RULES+rule]
first_vld  out  1  first-error capture valid
first_ch  out  clog2(NUM_CH) (min 1)  channel of first violation
first_rule  out  3  rule index of first violation
irq  out  1  registered OR of viol_sticky
xfer_cnt  out  NUM_CH*CNT_W  completed transfers per channel, saturating

Behaviour:
- Reset (async): all outputs 0; every channel FSM in IDLE; timeout counters 0.
- Rule indices:
  - 0 VALID_DROP: valid fell while in WAIT.
  - 1 PAYLOAD_CHG: data/offset/size differs from captured value while in WAIT and valid is high.
  - 2 SIZE_OFS: valid && size+offset > DATA_WIDTH/8, with SIZE_WIDTH+1-bit arithmetic (no wrap).
  - 3 SIZE0: valid && size==0; suppressed when ALLOW_SIZE0=1.
  - 4 ERR_OUTSIDE: err && !(valid && ready).
  - 5 TIMEOUT: stall counter reaches timeout_limit, with timeout_limit != 0.
- X/unknown checks are not implemented: simulation-only, excluded.
- Per-channel FSM:
  - IDLE: valid && !ready -> WAIT; capture data/offset/size; stall counter = 1.
  - IDLE: valid && ready -> stays IDLE; transfer completes.
  - WAIT: valid && ready -> IDLE; transfer completes.
  - WAIT: !valid -> IDLE; VALID_DROP.
  - WAIT: valid && !ready -> stays WAIT; stall counter increments, saturating at all-ones.
- TIMEOUT fires exactly once per stalled transfer, on the edge where the counter equals timeout_limit. Not re-armed until return to IDLE.
- Completion: xfer_cnt[ch] +1 on the valid&&ready edge, saturating at 2^CNT_W-1. Counts regardless of violations. A completion that also violates still counts.
- Latency: inputs sampled at posedge N; sticky bit and first capture visible after edge N; irq visible after edge N+1.
- Sticky bits hold until clr or reset.
- First capture: latched only while first_vld==0. Multiple violations in one cycle: lowest channel wins, then lowest rule index.
- clr on the same edge as a new violation: clear applies first, then the new violation sets its bit and is captured as first. Same ordering for xfer_cnt: cleared, then +1 if completing.
- clr does not alter FSM state or stall counters.
- chk_en[ch]=0:
  - forces that channel's FSM to IDLE and stall counter to 0;
  - suppresses all violations for that channel;
  - xfer_cnt still counts.
  - Rising chk_en mid-transfer starts from IDLE; no spurious VALID_DROP.
- timeout_limit changing mid-stall takes effect immediately. A limit already passed does not fire.

Decomposition:
- Package cfs_md_chk_pkg: rule enum (VALID_DROP..TIMEOUT), NUM_RULES, channel state enum (IDLE, WAIT), helper function for OFFSET_WIDTH/SIZE_WIDTH.
- Sub-module cfs_md_chk_channel: one per channel. Contains FSM, capture registers, stall counter, xfer counter, per-rule violation pulses.
- Top: generate loop, sticky/first-error priority encoder, irq.

Test Plan:
- Ch0: valid=1, ready=0 for 3 cycles, data 'hA5A5_0000 held, then ready=1 -> xfer_cnt[0]=1, viol_sticky=0, irq=0.
- Ch1 in WAIT: data changes 'h11 -> 'h22 with ready=0 -> bit 1*6+1 set next cycle, first_ch=1, first_rule=1, irq=1 one cycle later.
- Ch0: offset=3, size=2, DATA_WIDTH=32 -> SIZE_OFS set. Same cycle ch1 VALID_DROP -> first_ch=0, first_rule=2.
- timeout_limit=4, ch0 stalled 10 cycles -> TIMEOUT pulse only on 4th stall edge; sticky stays set; irq=1.
- clr pulsed on the same edge ch1 asserts err with valid=0 -> all flags clear except ch1 ERR_OUTSIDE; first_rule=4.
- Assert reset_n low mid-WAIT on ch0 with sticky bits set -> all outputs 0 immediately. After release, a ready-only pulse causes no VALID_DROP.
